// File: rtl/multi_drop_bus_if.sv
// Shared read-side bus bundle: four source request/data/grant sets plus the
// valid/ready databus toward the consumer and the completion/abort pulses.
interface multi_drop_bus_if #(
  parameter int DATA_W = 16
);
  logic              A_req, B_req, C_req, D_req;
  logic [DATA_W-1:0] DataA, DataB, DataC, DataD;
  logic              A_gnt, B_gnt, C_gnt, D_gnt;
  logic [DATA_W-1:0] databus;
  logic              bus_valid;
  logic              bus_ready;
  logic              xfer_done;
  logic              timeout;

  modport master (
    input  A_req, B_req, C_req, D_req,
    input  DataA, DataB, DataC, DataD,
    input  bus_ready,
    output A_gnt, B_gnt, C_gnt, D_gnt,
    output databus, bus_valid, xfer_done, timeout
  );

  modport slave (
    output A_req, B_req, C_req, D_req,
    output DataA, DataB, DataC, DataD,
    output bus_ready,
    input  A_gnt, B_gnt, C_gnt, D_gnt,
    input  databus, bus_valid, xfer_done, timeout
  );
endinterface

// File: rtl/multi_drop_bus_driver.sv
// Round-robin arbiter for four bus sources: grants one source per transfer, holds its
// captured word on databus under valid/ready, and aborts transfers stalled too long.
module multi_drop_bus_driver #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic              Clock,
  input logic              Reset,
  multi_drop_bus_if.master bus
);
  localparam int               CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit               WDOG_EN  = (TIMEOUT != 0);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state;
  logic [3:0]        gnt_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              done_r;
  logic              to_r;
  logic [1:0]        cur_r;
  logic [1:0]        ptr_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [3:0]        req_vec;
  logic              any_req;
  logic [1:0]        last_src;
  logic [1:0]        nxt_src;
  logic [DATA_W-1:0] nxt_data;

  // Walks from farthest to nearest after 'last' so the nearest requester wins;
  // 'last' itself is visited first, making it the lowest-priority candidate.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign req_vec  = {bus.D_req, bus.C_req, bus.B_req, bus.A_req};
  assign any_req  = |req_vec;
  // During DRIVE the source being served is the one that will become last-granted.
  assign last_src = (state == DRIVE) ? cur_r : ptr_r;
  assign nxt_src  = rr_pick(req_vec, last_src);

  always_comb begin
    case (nxt_src)
      2'd0:    nxt_data = bus.DataA;
      2'd1:    nxt_data = bus.DataB;
      2'd2:    nxt_data = bus.DataC;
      default: nxt_data = bus.DataD;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      gnt_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      to_r    <= 1'b0;
      cur_r   <= 2'd0;
      ptr_r   <= 2'd3;
      cnt_r   <= '0;
    end else begin
      done_r <= 1'b0;
      to_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= DRIVE;
            gnt_r   <= 4'b0001 << nxt_src;
            data_r  <= nxt_data;
            valid_r <= 1'b1;
            cur_r   <= nxt_src;
            cnt_r   <= '0;
          end
        end
        DRIVE: begin
          if (bus.bus_ready) begin
            done_r <= 1'b1;
            ptr_r  <= cur_r;
            if (any_req) begin
              gnt_r  <= 4'b0001 << nxt_src;
              data_r <= nxt_data;
              cur_r  <= nxt_src;
              cnt_r  <= '0;
            end else begin
              state   <= IDLE;
              gnt_r   <= '0;
              data_r  <= '0;
              valid_r <= 1'b0;
            end
          end else if (WDOG_EN && cnt_r == CNT_LAST) begin
            // Abort never chains into a new grant; arbitration resumes from IDLE.
            to_r    <= 1'b1;
            ptr_r   <= cur_r;
            state   <= IDLE;
            gnt_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A_gnt     = gnt_r[0];
  assign bus.B_gnt     = gnt_r[1];
  assign bus.C_gnt     = gnt_r[2];
  assign bus.D_gnt     = gnt_r[3];
  assign bus.databus   = data_r;
  assign bus.bus_valid = valid_r;
  assign bus.xfer_done = done_r;
  assign bus.timeout   = to_r;
endmodule

// File: tb/tb_multi_drop_bus_driver.sv
// Bench for multi_drop_bus_driver: directed scenarios plus randomized traffic against
// a transaction-level reference model; a second instance has the watchdog disabled.
module tb_multi_drop_bus_driver;
  localparam int DW    = 16;
  localparam int TO_TB = 15;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    req;
  logic [DW-1:0] data [4];
  logic          ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  multi_drop_bus_if #(.DATA_W(DW)) ifc ();
  multi_drop_bus_if #(.DATA_W(DW)) ifz ();

  assign ifc.A_req = req[0];  assign ifz.A_req = req[0];
  assign ifc.B_req = req[1];  assign ifz.B_req = req[1];
  assign ifc.C_req = req[2];  assign ifz.C_req = req[2];
  assign ifc.D_req = req[3];  assign ifz.D_req = req[3];
  assign ifc.DataA = data[0]; assign ifz.DataA = data[0];
  assign ifc.DataB = data[1]; assign ifz.DataB = data[1];
  assign ifc.DataC = data[2]; assign ifz.DataC = data[2];
  assign ifc.DataD = data[3]; assign ifz.DataD = data[3];
  assign ifc.bus_ready = ready;
  assign ifz.bus_ready = ready;

  multi_drop_bus_driver #(.DATA_W(DW), .TIMEOUT(TO_TB)) dut (
    .Clock(Clock), .Reset(Reset), .bus(ifc.master));
  multi_drop_bus_driver #(.DATA_W(DW), .TIMEOUT(0)) dutz (
    .Clock(Clock), .Reset(Reset), .bus(ifz.master));

  // Transaction-level model of the TIMEOUT=15 instance.
  bit            m_busy;
  int            m_src, m_ptr, m_wait;
  logic [DW-1:0] m_data;
  bit            m_done, m_to;

  function automatic int next_src(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_src = 0; m_ptr = 3; m_wait = 0; m_data = '0; m_done = 0; m_to = 0;
  endtask

  task automatic model_grant(int n);
    m_busy = 1; m_src = n; m_data = data[n]; m_wait = 0;
  endtask

  task automatic model_update();
    int n;
    m_done = 0; m_to = 0;
    if (!m_busy) begin
      n = next_src(m_ptr, req);
      if (n >= 0) model_grant(n);
    end else if (ready) begin
      m_done = 1; m_ptr = m_src; m_busy = 0;
      n = next_src(m_src, req);
      if (n >= 0) model_grant(n);
    end else begin
      m_wait++;
      if (m_wait == TO_TB) begin
        m_to = 1; m_ptr = m_src; m_busy = 0;
      end
    end
  endtask

  function automatic logic [22:0] exp_vec();
    logic [3:0] g;
    g = m_busy ? 4'(1 << m_src) : 4'b0000;
    return {g, m_busy, m_done, m_to, m_busy ? m_data : 16'h0000};
  endfunction

  function automatic logic [22:0] act_vec();
    return {ifc.D_gnt, ifc.C_gnt, ifc.B_gnt, ifc.A_gnt,
            ifc.bus_valid, ifc.xfer_done, ifc.timeout, ifc.databus};
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    req = '0; ready = 1'b0;
    Reset = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] z;
    Reset = 1'b0; req = '0; ready = 1'b0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    model_reset();
    #1;
    z = {ifz.D_gnt, ifz.C_gnt, ifz.B_gnt, ifz.A_gnt,
         ifz.bus_valid, ifz.xfer_done, ifz.timeout, ifz.databus};
    n_checks++;
    if (act_vec() !== 23'h0) begin
      n_fail++; $display("FAIL reset_state got=%h want=%h", act_vec(), 23'h0);
    end
    n_checks++;
    if (z !== 23'h0) begin
      n_fail++; $display("FAIL reset_state_nowdog got=%h want=%h", z, 23'h0);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; data[0] = 16'h0088; ready = 1'b1;
    tick();
    req = '0;
    n_checks++;
    if (act_vec() !== {4'b0001, 1'b1, 1'b0, 1'b0, 16'h0088}) begin
      n_fail++; $display("FAIL single_grant got=%h want=%h", act_vec(),
                         {4'b0001, 1'b1, 1'b0, 1'b0, 16'h0088});
    end
    tick();
    n_checks++;
    if (act_vec() !== {4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL single_done got=%h want=%h", act_vec(),
                         {4'b0000, 1'b0, 1'b1, 1'b0, 16'h0000});
    end
    tick();
    n_checks++;
    if (act_vec() !== 23'h0) begin
      n_fail++; $display("FAIL single_idle got=%h want=%h", act_vec(), 23'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) data[i] = 16'hA000 + 16'(i);
    req = 4'hF; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      want = {4'(1 << (k % 4)), 1'b1, (k > 0), 1'b0, 16'hA000 + 16'(k % 4)};
      n_checks++;
      if (act_vec() !== want) begin
        n_fail++; $display("FAIL b2b_cycle%0d got=%h want=%h", k, act_vec(), want);
      end
    end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_stall_hold();
    int dones;
    do_reset();
    req = 4'b0010; data[1] = 16'h0077; ready = 1'b0;
    tick();
    req = '0; data[1] = 16'h1234;
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      dones += int'(ifc.xfer_done);
      n_checks++;
      if ({ifc.B_gnt, ifc.bus_valid, ifc.databus} !== {1'b1, 1'b1, 16'h0077}) begin
        n_fail++; $display("FAIL stall_hold%0d got=%h want=%h", k,
                           {ifc.B_gnt, ifc.bus_valid, ifc.databus}, {1'b1, 1'b1, 16'h0077});
      end
    end
    ready = 1'b1;
    tick();
    dones += int'(ifc.xfer_done);
    ready = 1'b0;
    tick();
    dones += int'(ifc.xfer_done);
    n_checks++;
    if (dones !== 1 || ifc.bus_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_done got=%0d/%b want=1/0", dones, ifc.bus_valid);
    end
  endtask

  task automatic test_timeout();
    int vcycles, to_pulses, to_at;
    logic [3:0] want_g [4];
    logic [3:0] got_g;
    do_reset();
    req = 4'b0100; data[2] = 16'hC0C0; ready = 1'b0;
    tick();
    req = '0;
    n_checks++;
    if ({ifc.C_gnt, ifc.bus_valid} !== 2'b11) begin
      n_fail++; $display("FAIL to_grant got=%b want=11", {ifc.C_gnt, ifc.bus_valid});
    end
    vcycles = 0; to_pulses = 0; to_at = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ifc.bus_valid) vcycles++;
      if (ifc.timeout) begin to_pulses++; to_at = i; end
    end
    n_checks++;
    if (vcycles + 1 !== 15 || to_pulses !== 1 || to_at !== 14) begin
      n_fail++; $display("FAIL to_window got=valid%0d/pulses%0d/at%0d want=15/1/14",
                         vcycles + 1, to_pulses, to_at);
    end
    // after aborting C, C must come last in rotation
    want_g[0] = 4'b1000; want_g[1] = 4'b0001; want_g[2] = 4'b0010; want_g[3] = 4'b0100;
    req = 4'hF; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      got_g = {ifc.D_gnt, ifc.C_gnt, ifc.B_gnt, ifc.A_gnt};
      n_checks++;
      if (got_g !== want_g[k]) begin
        n_fail++; $display("FAIL to_fair%0d got=%b want=%b", k, got_g, want_g[k]);
      end
    end
    req = '0;
    repeat (2) tick();
  endtask

  task automatic test_no_watchdog();
    int bad;
    do_reset();
    req = 4'b0001; data[0] = 16'h5A5A; ready = 1'b0;
    tick();
    req = '0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifz.bus_valid !== 1'b1 || ifz.timeout !== 1'b0 || ifz.databus !== 16'h5A5A) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL nowdog_hold got=%0d bad cycles want=0", bad);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_checks++;
    if ({ifz.xfer_done, ifz.timeout, ifz.bus_valid} !== 3'b100) begin
      n_fail++; $display("FAIL nowdog_done got=%b want=100",
                         {ifz.xfer_done, ifz.timeout, ifz.bus_valid});
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    req = 4'b1000; data[3] = 16'hBEEF; ready = 1'b0;
    tick();
    req = '0;
    n_checks++;
    if (act_vec() !== {4'b1000, 1'b1, 1'b0, 1'b0, 16'hBEEF}) begin
      n_fail++; $display("FAIL rstmid_grant got=%h want=%h", act_vec(),
                         {4'b1000, 1'b1, 1'b0, 1'b0, 16'hBEEF});
    end
    #2 Reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (act_vec() !== 23'h0) begin
      n_fail++; $display("FAIL rstmid_async got=%h want=%h", act_vec(), 23'h0);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge Clock); #1;
      pulses += int'(ifc.xfer_done) + int'(ifc.timeout);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL rstmid_pulses got=%0d want=0", pulses);
    end
    req = 4'b1001; data[0] = 16'h1111; ready = 1'b1;
    Reset = 1'b1;
    tick();
    req = '0;
    n_checks++;
    if (act_vec() !== {4'b0001, 1'b1, 1'b0, 1'b0, 16'h1111}) begin
      n_fail++; $display("FAIL rstmid_regrant got=%h want=%h", act_vec(),
                         {4'b0001, 1'b1, 1'b0, 1'b0, 16'h1111});
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [3:0] g;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req = 4'($urandom);
      for (int i = 0; i < 4; i++) data[i] = 16'($urandom);
      // alternate phases of brisk and sluggish consumers so aborts get exercised
      if ((c / 100) % 2 == 1) ready = ($urandom_range(0, 15) == 0);
      else                    ready = ($urandom_range(0, 1) == 1);
      if ((c / 100) % 4 == 3) req = (req & 4'($urandom)) & 4'($urandom);
      tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_c%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
      g = {ifc.D_gnt, ifc.C_gnt, ifc.B_gnt, ifc.A_gnt};
      n_checks++;
      if (!$onehot0(g) || ((g != 4'b0) !== ifc.bus_valid) || (ifc.xfer_done && ifc.timeout)) begin
        n_fail++; $display("FAIL random_inv%0d got=gnt%b/valid%b/done%b/to%b want=consistent",
                           c, g, ifc.bus_valid, ifc.xfer_done, ifc.timeout);
      end
    end
    req = '0; ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=time limit want=bench completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall_hold();
    test_timeout();
    test_no_watchdog();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
